// File: rtl/cursor_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_select_ctrl
//  Description : Board cursor plus a two-tile select/deselect state machine.
//                It consumes keyboard operation pulses and issues a registered
//                valid/ready swap request when two adjacent tiles are chosen.
//  Revision    : 1.0  initial release
// ============================================================================
module cursor_select_ctrl #(
  parameter int COLS  = 8,
  parameter int ROWS  = 8,
  parameter int COL_W = 3,
  parameter int ROW_W = 3,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op,
  output logic [COL_W-1:0] cur_x,
  output logic [ROW_W-1:0] cur_y,
  output logic             sel_valid,
  output logic [COL_W-1:0] sel_x,
  output logic [ROW_W-1:0] sel_y,
  output logic             req_valid,
  output logic [COL_W-1:0] req_x0,
  output logic [ROW_W-1:0] req_y0,
  output logic [COL_W-1:0] req_x1,
  output logic [ROW_W-1:0] req_y1,
  input  logic             req_ready,
  output logic [15:0]      move_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ONE_SEL = 2'd1,
    REQ     = 2'd2
  } state_t;

  localparam logic [COL_W-1:0] X_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] Y_MAX   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] X_ONE   = COL_W'(1);
  localparam logic [ROW_W-1:0] Y_ONE   = ROW_W'(1);
  localparam bit               WRAP_EN = (WRAP != 0);

  state_t           state, state_nxt;
  logic [COL_W-1:0] cur_x_nxt, sel_x_nxt, req_x0_nxt, req_x1_nxt;
  logic [ROW_W-1:0] cur_y_nxt, sel_y_nxt, req_y0_nxt, req_y1_nxt;
  logic             sel_valid_nxt, req_valid_nxt;
  logic [15:0]      move_cnt_nxt;

  // Priority decode: only the highest-priority pulse of a cycle is acted on.
  logic do_sel, do_left, do_right, do_up, do_down;
  assign do_sel   = op[0];
  assign do_left  = op[1] & ~op[0];
  assign do_right = op[2] & ~|op[1:0];
  assign do_up    = op[3] & ~|op[2:0];
  assign do_down  = op[4] & ~|op[3:0];

  // Edge detection; a move off an edge is only accepted when wrapping.
  logic at_left, at_right, at_top, at_bot, move_ok;
  assign at_left  = (cur_x == '0);
  assign at_right = (cur_x == X_MAX);
  assign at_top   = (cur_y == '0);
  assign at_bot   = (cur_y == Y_MAX);
  assign move_ok  = (do_left  & (~at_left  | WRAP_EN)) |
                    (do_right & (~at_right | WRAP_EN)) |
                    (do_up    & (~at_top   | WRAP_EN)) |
                    (do_down  & (~at_bot   | WRAP_EN));

  // Plain unsigned distance, so wrap-around never creates adjacency.
  logic [COL_W-1:0] dx;
  logic [ROW_W-1:0] dy;
  logic             same_tile, adjacent;
  assign dx        = (cur_x >= sel_x) ? (cur_x - sel_x) : (sel_x - cur_x);
  assign dy        = (cur_y >= sel_y) ? (cur_y - sel_y) : (sel_y - cur_y);
  assign same_tile = (dx == '0) && (dy == '0);
  assign adjacent  = ((dx == X_ONE) && (dy == '0)) || ((dx == '0) && (dy == Y_ONE));

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_nxt     = state;
    cur_x_nxt     = cur_x;
    cur_y_nxt     = cur_y;
    sel_valid_nxt = sel_valid;
    sel_x_nxt     = sel_x;
    sel_y_nxt     = sel_y;
    req_valid_nxt = req_valid;
    req_x0_nxt    = req_x0;
    req_y0_nxt    = req_y0;
    req_x1_nxt    = req_x1;
    req_y1_nxt    = req_y1;
    move_cnt_nxt  = move_cnt;
    case (state)
      IDLE, ONE_SEL: begin
        if (do_sel) begin
          if (state == IDLE || !(same_tile || adjacent)) begin
            // Fresh selection, or re-selection at a non-adjacent tile.
            sel_valid_nxt = 1'b1;
            sel_x_nxt     = cur_x;
            sel_y_nxt     = cur_y;
            state_nxt     = ONE_SEL;
          end else if (same_tile) begin
            sel_valid_nxt = 1'b0;
            state_nxt     = IDLE;
          end else begin
            req_valid_nxt = 1'b1;
            req_x0_nxt    = sel_x;
            req_y0_nxt    = sel_y;
            req_x1_nxt    = cur_x;
            req_y1_nxt    = cur_y;
            state_nxt     = REQ;
          end
        end else begin
          if (do_left)  cur_x_nxt = at_left  ? (WRAP_EN ? X_MAX : cur_x) : cur_x - X_ONE;
          if (do_right) cur_x_nxt = at_right ? (WRAP_EN ? '0    : cur_x) : cur_x + X_ONE;
          if (do_up)    cur_y_nxt = at_top   ? (WRAP_EN ? Y_MAX : cur_y) : cur_y - Y_ONE;
          if (do_down)  cur_y_nxt = at_bot   ? (WRAP_EN ? '0    : cur_y) : cur_y + Y_ONE;
          if (move_ok && move_cnt != 16'hFFFF) move_cnt_nxt = move_cnt + 16'd1;
        end
      end
      REQ: begin
        // Ops are dropped here; only the handshake can leave this state.
        if (req_ready) begin
          req_valid_nxt = 1'b0;
          sel_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_x     <= '0;
      cur_y     <= '0;
      sel_valid <= 1'b0;
      sel_x     <= '0;
      sel_y     <= '0;
      req_valid <= 1'b0;
      req_x0    <= '0;
      req_y0    <= '0;
      req_x1    <= '0;
      req_y1    <= '0;
      move_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cur_x     <= cur_x_nxt;
      cur_y     <= cur_y_nxt;
      sel_valid <= sel_valid_nxt;
      sel_x     <= sel_x_nxt;
      sel_y     <= sel_y_nxt;
      req_valid <= req_valid_nxt;
      req_x0    <= req_x0_nxt;
      req_y0    <= req_y0_nxt;
      req_x1    <= req_x1_nxt;
      req_y1    <= req_y1_nxt;
      move_cnt  <= move_cnt_nxt;
    end
  end

endmodule
`default_nettype wire
